// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and widths for the stopwatch controller
//
// Purpose: state encoding constants, state enum and default time width used by
//          stopwatch_controller and its bench.
// Contents: ST_IDLE/ST_RUNNING/ST_LAP/ST_PAUSED, STATE_W, TIME_WIDTH_DEFAULT, state_e.
package stopwatch_pkg;

  localparam int STATE_W            = 2;
  localparam int TIME_WIDTH_DEFAULT = 16;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUNNING = 2'b01;
  localparam logic [STATE_W-1:0] ST_LAP     = 2'b10;
  localparam logic [STATE_W-1:0] ST_PAUSED  = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_RUNNING = ST_RUNNING,
    S_LAP     = ST_LAP,
    S_PAUSED  = ST_PAUSED
  } state_e;

endpackage

// File: rtl/stopwatch_controller_edge_detect.sv
// rtl/stopwatch_controller_edge_detect.sv - rising-edge pulse generator for a debounced button
//
// Purpose: one-cycle pulse on each rising edge of level. A level already high
//          when reset releases is not reported until it drops and rises again.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   level in  debounced button level
//   pulse out one-cycle rising-edge pulse (combinational from level)
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_q, prev_d;
  // armed goes high once the button has been seen released after reset,
  // so a button held through reset release cannot fake a press.
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = level;
    armed_d = armed_q | ~level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign pulse = level & ~prev_q & armed_q;

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - run/pause/lap/clear sequencing for the stopwatch
//
// Purpose: turns start/stop and lap/reset button presses into FSM sequencing,
//          gates timebase ticks into count enables, and owns the display register
//          (frozen while in LAP).
// Optional feature macro: STOPWATCH_OVERFLOW_STOP_EN (stop at MAX_TIME).
// Ports:
//   clk            in   board clock
//   rst            in   asynchronous active-high reset
//   btn_start_stop in   debounced start/stop level
//   btn_lap_reset  in   debounced lap/reset level
//   tick           in   one-cycle timebase pulse
//   time_in        in   current counter chain value
//   count_enable   out  registered one-cycle increment pulse
//   count_clear    out  registered one-cycle clear pulse
//   display_value  out  registered display value
//   running        out  high in RUNNING or LAP
//   state_out      out  current state encoding
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int                    TIME_WIDTH = TIME_WIDTH_DEFAULT,
  parameter logic [TIME_WIDTH-1:0] MAX_TIME   = {TIME_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_start_stop,
  input  logic                  btn_lap_reset,
  input  logic                  tick,
  input  logic [TIME_WIDTH-1:0] time_in,
  output logic                  count_enable,
  output logic                  count_clear,
  output logic [TIME_WIDTH-1:0] display_value,
  output logic                  running,
  output logic [STATE_W-1:0]    state_out
);

  logic start_p, lap_p;

  edge_detect u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_start_stop),
    .pulse (start_p)
  );

  edge_detect u_lap_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_lap_reset),
    .pulse (lap_p)
  );

  state_e                state_q, state_d;
  logic                  count_enable_q, count_enable_d;
  logic                  count_clear_q, count_clear_d;
  logic [TIME_WIDTH-1:0] display_q, display_d;
  logic                  running_q, running_d;
  logic                  counting;
  logic                  start_ok;

  always_comb begin
    state_d        = state_q;
    count_clear_d  = 1'b0;
    display_d      = time_in;
    counting       = (state_q == S_RUNNING) || (state_q == S_LAP);
    count_enable_d = tick & counting;

`ifdef STOPWATCH_OVERFLOW_STOP_EN
    // A paused stopwatch sitting at its final value can only be reset.
    start_ok = start_p && (time_in != MAX_TIME);
`else
    start_ok = start_p;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_p) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (start_p)    state_d = S_PAUSED;
        else if (lap_p) state_d = S_LAP;
      end
      S_LAP: begin
        if (start_p)    state_d = S_PAUSED;
        else if (lap_p) state_d = S_RUNNING;
      end
      S_PAUSED: begin
        if (start_ok) begin
          state_d = S_RUNNING;
        end else if (lap_p) begin
          state_d       = S_IDLE;
          count_clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef STOPWATCH_OVERFLOW_STOP_EN
    // Reaching the final value swallows the tick and forces a pause,
    // overriding any button action in the same cycle.
    if (counting && tick && (time_in == MAX_TIME)) begin
      count_enable_d = 1'b0;
      state_d        = S_PAUSED;
    end
`endif

    // Entering LAP captures time_in (same as following); staying in LAP holds.
    if ((state_q == S_LAP) && (state_d == S_LAP)) display_d = display_q;

    running_d = (state_d == S_RUNNING) || (state_d == S_LAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      count_enable_q <= 1'b0;
      count_clear_q  <= 1'b0;
      display_q      <= '0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_enable_q <= count_enable_d;
      count_clear_q  <= count_clear_d;
      display_q      <= display_d;
      running_q      <= running_d;
    end
  end

  assign count_enable  = count_enable_q;
  assign count_clear   = count_clear_q;
  assign display_value = display_q;
  assign running       = running_q;
  assign state_out     = state_q;

endmodule
